// File: rtl/n_bit_register_file_if.sv
// Bus bundle for n_bit_register_file: one write port, two read addresses and the two
// registered read-data returns. WIDTH/DEPTH must match the attached register file.
interface n_bit_register_file_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             Clr;
  logic             WE;
  logic [AW-1:0]    WAddr;
  logic [WIDTH-1:0] nBitIn;
  logic [AW-1:0]    RAddrA;
  logic [AW-1:0]    RAddrB;
  logic [WIDTH-1:0] YA;
  logic [WIDTH-1:0] YB;

  modport master (
    output Clr, WE, WAddr, nBitIn, RAddrA, RAddrB,
    input  YA, YB
  );

  modport slave (
    input  Clr, WE, WAddr, nBitIn, RAddrA, RAddrB,
    output YA, YB
  );
endinterface

// File: rtl/n_bit_register_file.sv
// DEPTH x WIDTH register file, one write port, two registered read ports, synchronous bulk clear.
// Define REGFILE_BYPASS_EN to forward same-edge write data onto a matching read port.
module n_bit_register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic                  clk,
  input logic                  Reset,
  n_bit_register_file_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic                        waddr_ok;
  logic                        raddr_a_ok;
  logic                        raddr_b_ok;
  logic                        wr_en;
  logic [WIDTH-1:0]            ya_q, ya_d;
  logic [WIDTH-1:0]            yb_q, yb_d;

  // Extra top bit lets non-power-of-two depths reject the unused address codes.
  always_comb begin
    waddr_ok   = ({1'b0, bus.WAddr}  < DEPTH_LIM);
    raddr_a_ok = ({1'b0, bus.RAddrA} < DEPTH_LIM);
    raddr_b_ok = ({1'b0, bus.RAddrB} < DEPTH_LIM);
    wr_en      = bus.WE && waddr_ok;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (bus.Clr)
          entry_d = '0;
        else if (wr_en && (bus.WAddr == AW'(gi)))
          entry_d = bus.nBitIn;
      end

      always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) entry_q <= '0;
        else        entry_q <= entry_d;
      end

      assign entries[gi] = entry_q;
    end
  endgenerate

  always_comb begin
    ya_d = '0;
    yb_d = '0;
    if (raddr_a_ok) ya_d = entries[bus.RAddrA];
    if (raddr_b_ok) yb_d = entries[bus.RAddrB];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (bus.RAddrA == bus.WAddr)) ya_d = bus.nBitIn;
    if (wr_en && (bus.RAddrB == bus.WAddr)) yb_d = bus.nBitIn;
`endif
    // Clear wins over both the stored value and any forwarded write.
    if (bus.Clr) begin
      ya_d = '0;
      yb_d = '0;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ya_q <= '0;
      yb_q <= '0;
    end else begin
      ya_q <= ya_d;
      yb_q <= yb_d;
    end
  end

  assign bus.YA = ya_q;
  assign bus.YB = yb_q;
endmodule

// File: tb/tb_n_bit_register_file.sv
// Randomized and directed checks of n_bit_register_file (DEPTH=6, so codes 6/7 are out of range)
// against an array-based reference model; honours REGFILE_BYPASS_EN when defined.
module tb_n_bit_register_file;
  localparam int WIDTH = 32;
  localparam int DEPTH = 6;
  localparam int AW    = $clog2(DEPTH);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset;

  n_bit_register_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  n_bit_register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_ya, exp_yb;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int a);
    if (a < DEPTH) return ref_mem[a];
    return '0;
  endfunction

  function automatic logic [WIDTH-1:0] model_port(input bit we, input int wa,
                                                  input logic [WIDTH-1:0] din, input int ra);
    if (BYPASS && we && (wa < DEPTH) && (ra == wa)) return din;
    return model_read(ra);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_ya = '0;
    exp_yb = '0;
  endtask

  // Drives one transaction away from the edge, advances the model at the edge, checks #1 later.
  task automatic do_cycle(input bit clr, input bit we, input int wa,
                          input logic [WIDTH-1:0] din, input int ra, input int rb);
    bus.Clr    = clr;
    bus.WE     = we;
    bus.WAddr  = AW'(wa);
    bus.nBitIn = din;
    bus.RAddrA = AW'(ra);
    bus.RAddrB = AW'(rb);
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else begin
      exp_ya = model_port(we, wa, din, ra);
      exp_yb = model_port(we, wa, din, rb);
      if (we && (wa < DEPTH)) ref_mem[wa] = din;
    end
    #1;
    n_txn++;
    $display("txn %0d clr=%0b we=%0b wa=%0d din=%08h ra=%0d rb=%0d ya=%08h yb=%08h",
             n_txn, clr, we, wa, din, ra, rb, bus.YA, bus.YB);
    check("YA", bus.YA, exp_ya);
    check("YB", bus.YB, exp_yb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ra, wa;
    bit clr, we;

    Reset      = 1'b1;
    bus.Clr    = 1'b0;
    bus.WE     = 1'b0;
    bus.WAddr  = '0;
    bus.nBitIn = '0;
    bus.RAddrA = '0;
    bus.RAddrB = '0;
    model_clear();

    // Power-on reset, held across a couple of edges.
    #2 Reset = 1'b0;
    #1;
    check("rst_ya", bus.YA, '0);
    check("rst_yb", bus.YB, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ya", bus.YA, '0);
    @(negedge clk) Reset = 1'b1;

    for (int a = 0; a < 8; a++) do_cycle(1'b0, 1'b0, 0, '0, a, 7 - a);

    // Write then read back; neighbouring entry stays 0.
    do_cycle(1'b0, 1'b1, 3, 32'hDEADBEEF, 0, 0);
    do_cycle(1'b0, 1'b0, 0, '0, 3, 4);
    check("wr_rd_ya", bus.YA, 32'hDEADBEEF);
    check("wr_rd_yb", bus.YB, '0);

    // Same-edge write and read of entry 5.
    do_cycle(1'b0, 1'b1, 5, 32'h11111111, 0, 0);
    do_cycle(1'b0, 1'b1, 5, 32'h22222222, 5, 5);
    check("same_edge_ya", bus.YA, BYPASS ? 32'h22222222 : 32'h11111111);
    do_cycle(1'b0, 1'b0, 0, '0, 5, 3);
    check("after_write_ya", bus.YA, 32'h22222222);

    // Clear and write together: clear wins.
    do_cycle(1'b1, 1'b1, 2, 32'hFFFFFFFF, 2, 3);
    check("clr_ya", bus.YA, '0);
    check("clr_yb", bus.YB, '0);
    do_cycle(1'b0, 1'b0, 0, '0, 2, 5);
    check("clr_entry2", bus.YA, '0);

    // Out-of-range write and read.
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, i, 32'h1000_0000 + 32'(i), 7, 6);
    do_cycle(1'b0, 1'b1, 7, 32'h0000ABCD, 7, 6);
    check("oor_rd_ya", bus.YA, '0);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b0, 0, '0, i, DEPTH - 1 - i);

    // Asynchronous reset between edges, then a blocked write while held.
    do_cycle(1'b0, 1'b1, 1, 32'h5A5A5A5A, 0, 4);
    do_cycle(1'b0, 1'b0, 0, '0, 1, 1);
    check("pre_arst_ya", bus.YA, 32'h5A5A5A5A);
    #2 Reset = 1'b0;
    #1;
    check("arst_ya", bus.YA, '0);
    check("arst_yb", bus.YB, '0);
    model_clear();
    bus.WE     = 1'b1;
    bus.WAddr  = AW'(1);
    bus.nBitIn = 32'hFFFF0000;
    bus.RAddrA = AW'(1);
    @(posedge clk);
    #1;
    check("arst_hold_ya", bus.YA, '0);
    @(negedge clk) Reset = 1'b1;
    bus.WE = 1'b0;
    do_cycle(1'b0, 1'b0, 0, '0, 1, 0);
    check("arst_entry1", bus.YA, '0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      clr = ($urandom_range(0, 15) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = int'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
      do_cycle(clr, we, wa, $urandom, ra, int'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/n_bit_register_file.md
# n_bit_register_file

Parametrised multi-entry successor to the single n-bit write-enabled register: DEPTH registers of WIDTH bits, one write port and two registered read ports. Serves as the general-purpose register file feeding the datapath operand latches, with a synchronous bulk clear and optional write-to-read forwarding.

## Interface
Parameters:
- WIDTH, 32, data width of each entry and of all data ports
- DEPTH, 8, number of entries; legal range 2..256
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock for all state
- Reset  input  1  asynchronous, active-low reset; clears every entry and both read outputs
- Clr  input  1  synchronous clear of all entries, active-high
- WE  input  1  write enable, active-high
- WAddr  input  AW  write address
- nBitIn  input  WIDTH  write data
- RAddrA  input  AW  read address, port A
- RAddrB  input  AW  read address, port B
- YA  output  WIDTH  registered read data, port A
- YB  output  WIDTH  registered read data, port B

## Operation
- Storage: DEPTH entries, each a WIDTH-bit register with asynchronous active-low reset to 0.
- Write: at a rising edge with WE=1 and WAddr<DEPTH, entry[WAddr] <= nBitIn. WAddr>=DEPTH is ignored; no entry changes.
- Clear: at a rising edge with Clr=1, all entries <= 0, and YA, YB <= 0. Clr has priority over WE; a write in the same cycle is dropped.
- Read: at every rising edge, YA <= entry[RAddrA] and YB <= entry[RAddrB], using the pre-edge entry contents, subject to forwarding (see Configuration). An address >=DEPTH returns 0.
- Both ports may address the same entry, or the write entry, in the same cycle; there are no conflicts or stalls.
- Unwritten entries read 0 after reset.
- Reset asserted mid-operation forces all entries, YA and YB to 0 immediately, independent of clk. While Reset=0, writes and clears are blocked. The first edge after deassertion behaves normally.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on YA/YB after edge N and is held until edge N+1.
- Write latency is 1 cycle: data written at edge N is visible on a read port after edge N+1 without forwarding, or after edge N with forwarding.
- Clear: entries and outputs are 0 after the Clr edge.
- Reset values: YA=0, YB=0, all entries=0.
- No combinational path exists from any input to YA/YB.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - At an edge with WE=1, Clr=0, WAddr<DEPTH and RAddrX==WAddr, YX <= nBitIn instead of the stale entry.
  - Applies independently to each port.
  - Clr still forces 0.
- Undefined:
  - YX <= the old entry contents; the new value is first readable one cycle later.
  - Forwarding logic is absent from the netlist.

## Test plan
- Reset: drive Reset=0 with random entries loaded -> YA=YB=0 immediately. After release, read all 8 addresses -> all 0.
- Write/read: write 0xDEADBEEF to addr 3 at edge N, set RAddrA=3 at edge N+1 -> YA=0xDEADBEEF after edge N+1. YB on addr 4 stays 0.
- Same-cycle write and read of addr 5 (old value 0x11111111, new value 0x22222222):
  - With REGFILE_BYPASS_EN: YA=0x22222222 after that edge.
  - Without it: YA=0x11111111, then 0x22222222 one cycle later.
- Clr and WE together on addr 2 with data 0xFFFFFFFF -> after the edge, entry 2 reads 0 and YA=YB=0.
- Out of range with DEPTH=6: write 0xABCD to addr 7 -> entries 0..5 unchanged. Read addr 7 -> 0.
- Async reset between edges after writing 0x5A5A5A5A to addr 1 -> YA/YB drop to 0 without a clk edge. Entry 1 reads 0 after release.
